// File: rtl/s2p_seq_ctrl_pkg.sv
// s2p_pkg: shared types and constants for the serial-to-parallel sequencer
// and the shifter it controls.
//   state_t      : sequencer FSM state (IDLE, FILL, HOLD), 2-bit encoding
//   S2P_DEPTH    : shifter stages per frame
//   S2P_N        : log2 of the shifter word width
//   FRAME_CNT_W  : width of the completed-frame counter
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int S2P_DEPTH   = 8;
  localparam int S2P_N       = 4;
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/s2p_seq_ctrl_beat_counter.sv
// s2p_beat_counter: W-bit up counter with a synchronous clear and a
// terminal-count flag. It counts accepted beats and, when the timeout
// option is built, idle cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count up by one
//   cnt        : current count
//   tc         : high while cnt == TC
module s2p_beat_counter #(
  parameter int W  = 3,
  parameter int TC = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] TC_V = W'(TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TC_V);

endmodule

// File: rtl/s2p_seq_ctrl.sv
// s2p_seq_ctrl: control sequencer for the DEPTH-stage serial-to-parallel
// shifter. It accepts serial words, drives the shifter's shared clock
// enable, and presents a frame-valid once DEPTH words are in.
//
// Handshakes:
//   input side : a beat happens in any cycle where in_valid & in_ready are
//                both high; shift_en equals beat in that same cycle, so the
//                word is captured into stage 1 at that clock edge.
//   frame side : frame_valid is registered and held until a cycle with
//                frame_ready high; that edge drops frame_valid. frame_ready
//                with no frame pending is ignored. in_ready returns only the
//                cycle after release, never in the release cycle itself.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous abort of the current frame (highest priority)
//   in_valid     : serial source presents a word
//   in_ready     : sequencer can accept a word this cycle
//   shift_en     : clock enable to every shifter stage
//   frame_valid  : shifter holds a complete frame
//   frame_ready  : consumer takes the frame this cycle
//   beat_cnt     : beats accepted in the current frame
//   frame_cnt    : completed frames, wraps modulo 256
//   timeout_err  : one-cycle pulse on partial-frame abort (option only)
//   state_dbg    : current FSM state encoding
//
// Build option: define S2P_SEQ_CTRL_TIMEOUT_EN to abort a partial frame
// after TIMEOUT cycles without a beat in FILL. Without it the partial frame
// is held indefinitely and timeout_err stays 0.
module s2p_seq_ctrl
  import s2p_pkg::*;
#(
  parameter int N        = S2P_N,
  parameter int DEPTH    = S2P_DEPTH,
  parameter int TIMEOUT  = 16,
  localparam int CW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   shift_en,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [CW-1:0]          beat_cnt,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   timeout_err,
  output logic [1:0]             state_dbg
);

  state_t state;
  logic   beat;
  logic   beat_tc;
  logic   frame_done;
  logic   timeout_abort;

  // This block carries no data; N only documents the shifter pairing and
  // TIMEOUT is meaningful only with the option built.
  logic unused_params;
  assign unused_params = ^(N ^ TIMEOUT);

  assign in_ready   = (state != HOLD) && !flush;
  assign beat       = in_valid && in_ready;
  assign shift_en   = beat;
  assign state_dbg  = state;
  // beat is already zero under flush, so frame_done never races a flush.
  assign frame_done = (state == FILL) && beat && beat_tc;

  s2p_beat_counter #(
    .W  (CW),
    .TC (DEPTH - 1)
  ) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush || frame_done || timeout_abort),
    .inc   (beat),
    .cnt   (beat_cnt),
    .tc    (beat_tc)
  );

`ifdef S2P_SEQ_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] unused_idle_cnt;
  logic          idle_tc;
  logic          idle_clr;
  logic          idle_inc;

  // Counts consecutive beat-less cycles in FILL; starts from 0 on every
  // entry into FILL because it is held clear outside FILL.
  assign idle_clr      = (state != FILL) || beat || flush || timeout_abort;
  assign idle_inc      = (state == FILL) && !beat;
  assign timeout_abort = (state == FILL) && !beat && idle_tc && !flush;

  s2p_beat_counter #(
    .W  (TW),
    .TC (TIMEOUT - 1)
  ) u_idle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (idle_clr),
    .inc   (idle_inc),
    .cnt   (unused_idle_cnt),
    .tc    (idle_tc)
  );
`else
  assign timeout_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (flush) begin
        // A frame pending in HOLD is dropped without being counted.
        state       <= IDLE;
        frame_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (beat) state <= FILL;
          end
          FILL: begin
            if (frame_done) begin
              state       <= HOLD;
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 1'b1;
            end else if (timeout_abort) begin
              state       <= IDLE;
              timeout_err <= 1'b1;
            end
          end
          HOLD: begin
            if (frame_ready) begin
              state       <= IDLE;
              frame_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_s2p_seq_ctrl.sv
// Bench for s2p_seq_ctrl: directed steps in one initial block, a reference
// shifter driven by shift_en, and a word scoreboard checked when a frame
// is presented.
module tb_s2p_seq_ctrl;

  localparam int DEPTH   = 8;
  localparam int CW      = 3;
  localparam int W       = 16;
  localparam int TIMEOUT = 16;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          flush       = 1'b0;
  logic          in_valid    = 1'b0;
  logic          frame_ready = 1'b0;
  logic          in_ready;
  logic          shift_en;
  logic          frame_valid;
  logic          timeout_err;
  logic [CW-1:0] beat_cnt;
  logic [7:0]    frame_cnt;
  logic [1:0]    state_dbg;

  logic [W-1:0]  din = '0;
  logic [W-1:0]  stage [DEPTH];
  logic [W-1:0]  exp_q [$];
  int            total = 0;
  int            bad   = 0;
  logic          fv_prev = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  s2p_seq_ctrl #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .shift_en    (shift_en),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .beat_cnt    (beat_cnt),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // Reference shifter: stage[0] is stage 1, stage[DEPTH-1] the last stage.
  always @(posedge clk) begin
    if (shift_en) begin
      for (int k = DEPTH - 1; k > 0; k--) stage[k] <= stage[k-1];
      stage[0] <= din;
    end
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid && !fv_prev) begin
        chk("sb_words_avail", 32'(exp_q.size() >= DEPTH), 32'd1);
        if (exp_q.size() >= DEPTH) begin
          for (int k = 0; k < DEPTH; k++)
            chk($sformatf("sb_stage%0d", DEPTH - 1 - k), stage[DEPTH-1-k], exp_q.pop_front());
        end
      end
      if (frame_valid) chk("hold_no_shift", shift_en, 32'd0);
    end
    fv_prev = frame_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_step(input logic [W-1:0] w);
    in_valid = 1'b1;
    din      = w;
    exp_q.push_back(w);
    #1;
    chk("beat_in_ready", in_ready, 32'd1);
    chk("beat_shift_en", shift_en, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return W'($urandom_range(0, 16'hFFFF));
  endfunction

  task automatic chk_regs_zero(input string pfx);
    chk({pfx, "_beat_cnt"},    beat_cnt,    32'd0);
    chk({pfx, "_frame_cnt"},   frame_cnt,   32'd0);
    chk({pfx, "_frame_valid"}, frame_valid, 32'd0);
    chk({pfx, "_timeout_err"}, timeout_err, 32'd0);
    chk({pfx, "_state"},       state_dbg,   32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   exp_fc;
    logic saw_zero;

    // Reset state, checked before any clock edge.
    #2;
    chk_regs_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;

    // Continuous input, no consumer: 8 beats, then HOLD.
    for (int i = 0; i < DEPTH; i++) begin
      beat_step(W'(i + 1));
      chk("a_beat_cnt", beat_cnt, 32'((i + 1) % DEPTH));
      chk("a_frame_valid", frame_valid, 32'(i == DEPTH - 1));
    end
    chk("a_frame_cnt", frame_cnt, 32'd1);
    chk("a_state_hold", state_dbg, 32'd2);

    // Hold for 3 cycles with the source still offering words.
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("a_hold_in_ready", in_ready, 32'd0);
      chk("a_hold_shift_en", shift_en, 32'd0);
      tick();
      chk("a_hold_fv", frame_valid, 32'd1);
    end
    chk("a_last_stage", stage[DEPTH-1], 32'h1);
    chk("a_first_stage", stage[0], 32'h8);

    // Release: frame_valid falls at this edge, in_ready only afterwards.
    frame_ready = 1'b1;
    #1;
    chk("b_rel_in_ready", in_ready, 32'd0);
    tick();
    frame_ready = 1'b0;
    in_valid    = 1'b0;
    chk("b_rel_fv", frame_valid, 32'd0);
    chk("b_rel_state", state_dbg, 32'd0);
    #1;
    chk("b_post_in_ready", in_ready, 32'd1);

    // frame_ready with nothing pending is ignored.
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("b_stray_fv", frame_valid, 32'd0);
    chk("b_stray_frame_cnt", frame_cnt, 32'd1);
    chk("b_stray_beat_cnt", beat_cnt, 32'd0);

    // Gapped input: beat_cnt holds across idle cycles.
    for (int i = 0; i < DEPTH; i++) begin
      beat_step(W'(16'h10 + i));
      #1;
      chk("c_gap_shift_en", shift_en, 32'd0);
      tick();
      chk("c_beat_cnt", beat_cnt, 32'((i + 1) % DEPTH));
      chk("c_frame_valid", frame_valid, 32'(i == DEPTH - 1));
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("c_frame_cnt", frame_cnt, 32'd2);
    chk("c_fv_released", frame_valid, 32'd0);

    // Flush mid-fill at beat_cnt = 5.
    for (int i = 0; i < 5; i++) beat_step(rnd_word());
    chk("d_beat_cnt5", beat_cnt, 32'd5);
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("d_flush_in_ready", in_ready, 32'd0);
    chk("d_flush_shift_en", shift_en, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("d_flush_beat_cnt", beat_cnt, 32'd0);
    chk("d_flush_fv", frame_valid, 32'd0);
    chk("d_flush_frame_cnt", frame_cnt, 32'd2);
    chk("d_flush_state", state_dbg, 32'd0);

    // Flush while a frame is held: discarded, not counted twice.
    for (int i = 0; i < DEPTH; i++) beat_step(rnd_word());
    chk("d_hold_fv", frame_valid, 32'd1);
    chk("d_hold_frame_cnt", frame_cnt, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("d_hflush_fv", frame_valid, 32'd0);
    chk("d_hflush_frame_cnt", frame_cnt, 32'd3);
    chk("d_hflush_state", state_dbg, 32'd0);
    #1;
    chk("d_hflush_in_ready", in_ready, 32'd1);

    // 256 back-to-back frames, consumer always ready: frame_cnt wraps.
    exp_fc      = 3;
    saw_zero    = 1'b0;
    frame_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      for (int b = 0; b < DEPTH; b++) beat_step(rnd_word());
      exp_fc = (exp_fc + 1) % 256;
      chk("e_frame_cnt", frame_cnt, 32'(exp_fc));
      chk("e_fv", frame_valid, 32'd1);
      if (frame_cnt === 8'd0) saw_zero = 1'b1;
      tick();
      chk("e_fv_taken", frame_valid, 32'd0);
    end
    frame_ready = 1'b0;
    chk("e_wrapped", saw_zero, 32'd1);
    chk("e_final_frame_cnt", frame_cnt, 32'd3);

    // Asynchronous reset mid-fill: registered outputs clear with no edge.
    for (int i = 0; i < 3; i++) beat_step(rnd_word());
    chk("f_beat_cnt3", beat_cnt, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs_zero("f_async");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) beat_step(rnd_word());
    chk("f_post_frame_cnt", frame_cnt, 32'd1);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("f_post_fv", frame_valid, 32'd0);

`ifdef S2P_SEQ_CTRL_TIMEOUT_EN
    begin
      int first_at;
      int pulses;
      // Three beats then silence: single pulse TIMEOUT cycles later.
      for (int i = 0; i < 3; i++) beat_step(rnd_word());
      first_at = 0;
      pulses   = 0;
      for (int c = 1; c <= TIMEOUT + 8; c++) begin
        tick();
        if (timeout_err === 1'b1) begin
          pulses++;
          if (first_at == 0) first_at = c;
        end
      end
      exp_q.delete();
      chk("g_pulses", 32'(pulses), 32'd1);
      chk("g_pulse_at", 32'(first_at), 32'(TIMEOUT));
      chk("g_beat_cnt", beat_cnt, 32'd0);
      chk("g_state", state_dbg, 32'd0);
      chk("g_frame_cnt", frame_cnt, 32'd1);

      // Flush on the would-be timeout cycle suppresses the pulse.
      for (int i = 0; i < 3; i++) beat_step(rnd_word());
      for (int c = 1; c < TIMEOUT; c++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      chk("g_flush_terr", timeout_err, 32'd0);
      chk("g_flush_beat_cnt", beat_cnt, 32'd0);
      chk("g_flush_state", state_dbg, 32'd0);
      tick();
      chk("g_flush_terr_after", timeout_err, 32'd0);
    end
`endif

    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s2p_seq_ctrl.md
Name: s2p_seq_ctrl

Overview:
- Sequencer for the 8-stage serial-to-parallel word shifter (clock-enabled DFF chain, word width 2**N).
- Accepts serial words over a valid/ready handshake and drives the shifter's shared clock-enable.
- Counts DEPTH accepted beats, then presents a frame-valid to the downstream consumer and stalls input until the frame is taken.
- Sits between the serial source and the shifter/consumer; carries no data itself, only control.

Parameters:
- N, 4, log2 of shifter word width; kept for alignment with the shifter, and this block carries no data.
- DEPTH, 8, shifter stages per frame; fixed at 8 to match the shifter, legal range 2..256.
- CW, $clog2(DEPTH), beat-counter width (derived, not overridable).
- TIMEOUT, 16, idle cycles in FILL before abort; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock shared with the shifter.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current frame.
- in_valid  in  1  serial source has a word on the shifter input.
- in_ready  out  1  controller can accept a word this cycle.
- shift_en  out  1  clock-enable to all shifter stages.
- frame_valid  out  1  shifter outputs hold a complete frame.
- frame_ready  in  1  consumer takes the frame this cycle.
- beat_cnt  out  CW  beats accepted in the current frame.
- frame_cnt  out  8  completed frames, wraps 255->0.
- timeout_err  out  1  one-cycle pulse on partial-frame abort.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, beat_cnt=0, frame_cnt=0, frame_valid=0, timeout_err=0, idle counter=0.
- Beat definition: beat = in_valid & in_ready.
- shift_en = beat, combinational, same cycle. The word is captured into stage 1 at that edge. The first word of a frame is at the last stage when frame_valid rises.
- in_ready = (state != HOLD) & ~flush, combinational.
- IDLE: beat -> FILL, beat_cnt=1.
- FILL: each beat increments beat_cnt. A beat with beat_cnt==DEPTH-1 -> HOLD, with beat_cnt=0, frame_valid=1 and frame_cnt+1, all registered. frame_valid is high the cycle after the DEPTH-th beat (latency 1).
- HOLD: in_ready=0 and shift_en=0, so shifter contents are frozen. frame_valid stays high until frame_ready=1. At that edge: frame_valid=0 and state=IDLE. in_ready rises the next cycle, so there is no same-cycle accept/release overlap.
- frame_ready while frame_valid=0: ignored.
- flush=1 overrides all other events. Next state IDLE, beat_cnt=0, frame_valid=0. frame_cnt is unchanged, and a pending HOLD frame is discarded without counting. in_ready is forced to 0 during the flush cycle, so no shift occurs.
- in_valid may drop at any time in FILL. The partial frame is held indefinitely, unless the optional feature is compiled in.
- Reset mid-frame: immediate return to reset values. The shifter data itself is not cleared and is don't-care.
- frame_cnt wraps modulo 256 with no flag.

Optional Feature:
- Macro: S2P_SEQ_CTRL_TIMEOUT_EN.
- With the macro defined:
  - An idle counter runs in FILL. It increments on each cycle without a beat and clears on a beat.
  - When it reaches TIMEOUT-1 with no beat: next state IDLE, beat_cnt=0, idle counter=0, and timeout_err=1 for exactly one cycle.
  - frame_cnt is unchanged on abort. flush takes priority over timeout, and timeout_err stays 0 in that case.
- Without the macro: no idle counter exists, timeout_err is tied 0, and TIMEOUT is unused.

Decomposition:
- Package s2p_pkg holds:
  - state enum IDLE, FILL, HOLD as a 2-bit typedef;
  - S2P_DEPTH=8 and the default word exponent N=4, shared with the shifter instantiation;
  - FRAME_CNT_W=8.
- One natural sub-module, s2p_beat_counter: CW-bit counter with increment, synchronous clear and terminal-count output, reused for the optional idle counter.
- The FSM stays in the top module.

Test Plan:
- Reset release, in_valid=1 continuous, frame_ready=0 -> shift_en high for exactly 8 cycles; frame_valid=1 on cycle 9; in_ready=0 from cycle 9; beat_cnt sequence 1..7 then 0; frame_cnt=1.
- Words 0x1..0x8 shifted, frame_ready pulsed 3 cycles after frame_valid -> frame_valid falls at the pulse edge; in_ready=1 one cycle later; no shift_en during HOLD (last stage=0x1, stage 1=0x8 stable).
- in_valid toggling 1,0,1,0 -> frame_valid only after the 8th accepted beat (cycle 16); beat_cnt holds across gaps.
- flush at beat_cnt=5, then in HOLD with frame_valid=1 -> beat_cnt=0, frame_valid=0 next cycle, no shift_en in the flush cycle, frame_cnt not incremented by the discarded frame.
- 256 back-to-back frames with frame_ready=1 -> frame_cnt wraps to 0; rst_n pulsed low mid-FILL -> all outputs 0 immediately, without waiting for a clock edge.
- With S2P_SEQ_CTRL_TIMEOUT_EN and TIMEOUT=16: 3 beats then in_valid=0 -> timeout_err pulses exactly once 16 cycles after the last beat; state IDLE, beat_cnt=0; a simultaneous flush suppresses the pulse.
